// File: rtl/mips_regfile.sv
// mips_regfile: 32-entry MIPS register file with hardwired $0 and same-cycle write-to-read bypass
module mips_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r [DEPTH];
    logic [DEPTH-1:0]      we;
    logic                  byp1, byp2;
    // one-hot write enable gated by reg_write; $0 can never be written
    always_comb begin
        we = '0;
        we[write_reg] = reg_write;
        we[0] = 1'b0;
    end
    // storage: reset clears every entry and beats a coincident write
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (!rst_n) r[i] <= '0;
            else if (we[i]) r[i] <= write_data;
    end
    // bypass only when a write will actually land this edge
    always_comb begin
        byp1 = rst_n && reg_write && (write_reg == read_reg1);
        byp2 = rst_n && reg_write && (write_reg == read_reg2);
        read_data1 = (read_reg1 == '0) ? '0 : byp1 ? write_data : r[read_reg1];
        read_data2 = (read_reg2 == '0) ? '0 : byp2 ? write_data : r[read_reg2];
        dbg_data   = (dbg_addr == '0) ? '0 : r[dbg_addr];
    end
endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed vector table plus randomized checks against an array model
`timescale 1ns/1ps
module tb_mips_regfile;
    logic        clk = 1'b0;
    logic        rst_n, reg_write;
    logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
    logic [31:0] write_data, read_data1, read_data2, dbg_data;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m [32];

    typedef struct {
        logic        rn, we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  a1, a2, d;
        logic [31:0] e1, e2, ed;
    } vec_t;

    mips_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(read_data1), .read_data2(read_data2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        @(negedge clk);
        rst_n = rn; reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = a1; read_reg2 = a2; dbg_addr = d;
        #1;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (rst_n && reg_write && write_reg == a) return write_data;
        return m[a];
    endfunction

    task automatic mcheck(input string tag);
        chk({tag, "_rd1"}, read_data1, mread(read_reg1));
        chk({tag, "_rd2"}, read_data2, mread(read_reg2));
        chk({tag, "_dbg"}, dbg_data, m[dbg_addr]);
    endtask

    task automatic mupdate();
        if (!rst_n) for (int i = 0; i < 32; i++) m[i] = 32'h0;
        else if (reg_write && write_reg != 0) m[write_reg] = write_data;
    endtask

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 5, 0, 5, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[1]  = '{1, 0, 0, 32'h0, 5, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{0, 0, 0, 32'h0, 5, 0, 5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[3]  = '{1, 0, 0, 32'h0, 5, 5, 5, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{1, 1, 8, 32'h12345678, 0, 0, 8, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{1, 0, 0, 32'h0, 8, 8, 8, 32'h12345678, 32'h12345678, 32'h12345678};
        tbl[6]  = '{1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[7]  = '{1, 0, 0, 32'h0, 0, 8, 0, 32'h0, 32'h12345678, 32'h0};
        tbl[8]  = '{1, 1, 3, 32'h1, 3, 0, 3, 32'h1, 32'h0, 32'h0};
        tbl[9]  = '{1, 1, 3, 32'hA5A5A5A5, 0, 3, 3, 32'h0, 32'hA5A5A5A5, 32'h1};
        tbl[10] = '{1, 0, 0, 32'h0, 3, 3, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[11] = '{1, 1, 9, 32'h77, 9, 0, 9, 32'h77, 32'h0, 32'h0};
        tbl[12] = '{0, 1, 9, 32'h55, 9, 9, 9, 32'h77, 32'h77, 32'h77};
        tbl[13] = '{1, 0, 0, 32'h0, 9, 8, 9, 32'h0, 32'h0, 32'h0};
        tbl[14] = '{1, 1, 4, 32'h11, 4, 0, 4, 32'h11, 32'h0, 32'h0};
        tbl[15] = '{1, 1, 4, 32'h22, 4, 4, 4, 32'h22, 32'h22, 32'h11};
        tbl[16] = '{1, 0, 0, 32'h0, 4, 4, 4, 32'h22, 32'h22, 32'h22};
        tbl[17] = '{1, 0, 4, 32'h99, 4, 4, 4, 32'h22, 32'h22, 32'h22};
        tbl[18] = '{1, 0, 0, 32'h0, 4, 0, 4, 32'h22, 32'h0, 32'h22};

        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) m[i] = 32'h0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rn, tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].d);
            chk($sformatf("vec%0d_rd1", i), read_data1, tbl[i].e1);
            chk($sformatf("vec%0d_rd2", i), read_data2, tbl[i].e2);
            chk($sformatf("vec%0d_dbg", i), dbg_data, tbl[i].ed);
            mupdate();
        end

        drive(0, 1, 4, 32'h1234, 4, 4, 4);
        mupdate();
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            chk($sformatf("rstclr_dbg%0d", i), dbg_data, 32'h0);
            chk($sformatf("rstclr_rd%0d", i), read_data1, 32'h0);
        end

        for (int i = 1; i < 32; i++) begin
            drive(1, 1, 5'(i), i * 32'h01010101, 5'(i), 0, 5'(i));
            chk($sformatf("sweep_byp%0d", i), read_data1, i * 32'h01010101);
            mupdate();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
            chk($sformatf("sweep_rd1_%0d", i), read_data1, i * 32'h01010101);
            chk($sformatf("sweep_rd2_%0d", i), read_data2, (31 - i) * 32'h01010101);
            chk($sformatf("sweep_dbg_%0d", i), dbg_data, i * 32'h01010101);
        end

        for (int i = 0; i < 500; i++) begin
            logic [4:0] wr;
            wr = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 24) != 0, $urandom_range(0, 2) != 0, wr, $urandom,
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            mcheck($sformatf("rnd%0d", i));
            mupdate();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
